nios2_jtag_sysclk_action_bridge: RTL

// - Downstream stage of the debug-module TCK-side shift logic. Moves the 38-bit JTAG data word (sr)
//   and the 2-bit virtual IR from the TCK domain into the CPU clk domain.
// - Detects Update-DR and Update-IR events through synchronizers, captures sr into jdo, and decodes

---
 rtl/nios2_jtag_sysclk_action_bridge.sv | 119 +++++++++++
 1 files changed

// File: rtl/nios2_jtag_sysclk_action_bridge.sv
// JTAG TCK->clk action bridge: synchronizes Update-DR/IR levels, captures sr/ir_in, and issues
// one-cycle decoded action strobes. Define JTAG_SYNC3_EN for 3-flop synchronizer chains.

module nios2_jtag_sysclk_level_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lvl,
  output logic rise
);
  (* async_reg = "true" *) logic [STAGES-1:0] sync;
  (* async_reg = "true" *) logic              hist;
  logic [STAGES-1:0] vld_pipe;
  logic              armed;

  // vld_pipe marks when the sync output holds a real sample rather than its reset value, so a
  // level already high at reset release never arms the detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      hist     <= 1'b0;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      sync     <= {sync[STAGES-2:0], lvl};
      hist     <= sync[STAGES-1];
      vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
      armed    <= armed | (vld_pipe[STAGES-1] & ~sync[STAGES-1]);
    end
  end

  assign rise = sync[STAGES-1] & ~hist & armed;
endmodule

module nios2_jtag_sysclk_action_bridge #(
  parameter int JDO_W         = 38,
  parameter int IR_W          = 2,
  parameter int TRACECTRL_BIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [JDO_W-1:0] sr,
  input  logic [IR_W-1:0]  ir_in,
  input  logic             vs_udr,
  input  logic             vs_uir,
  output logic [JDO_W-1:0] jdo,
  output logic [12:0]      act_strb
);
`ifdef JTAG_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  logic [1:0]      rise;
  logic            udr_rise;
  logic            uir_rise;
  logic [IR_W-1:0] ir_q;
  logic            pend;
  logic [12:0]     dec;
  logic            a, b, c, d;

  nios2_jtag_sysclk_level_edge #(.STAGES(SYNC_STAGES)) u_edge [1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .lvl     ({vs_uir, vs_udr}),
    .rise    (rise)
  );

  assign udr_rise = rise[0];
  assign uir_rise = rise[1];

  assign a = jdo[34];
  assign b = jdo[35];
  assign c = jdo[36];
  assign d = jdo[37];

  always_comb begin
    dec = '0;
    case (ir_q)
      IR_W'(0): begin
        dec[0] = a;
        dec[1] = ~a;
        dec[2] = b;
      end
      IR_W'(1): begin
        dec[3] = ~d & c;
        dec[4] = ~d & ~c;
        dec[5] = d;
      end
      IR_W'(2): begin
        dec[6]  = ~c & d;
        dec[7]  = ~c & ~d;
        dec[8]  = c & ~b & d;
        dec[9]  = c & ~b & ~d;
        dec[10] = c & b & d;
        dec[11] = c & b & ~d;
      end
      IR_W'(3): dec[12] = jdo[TRACECTRL_BIT];
      default: dec = '0;
    endcase
  end

  // A rise landing while pend is set reloads jdo and defers the strobe, so only one is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo      <= '0;
      ir_q     <= '0;
      pend     <= 1'b0;
      act_strb <= '0;
    end else begin
      if (uir_rise) ir_q <= ir_in;
      if (udr_rise) jdo <= sr;
      pend     <= udr_rise;
      act_strb <= (pend && !udr_rise) ? dec : '0;
    end
  end
endmodule
